instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit that supplies machine code to the control decoder. It owns the program counter and reads the instruction ROM (asynchronous read). It registers each fetched 9-bit instruction with its PC and applies branch redirects, stalls and halt. It sits between instrROM and Ctrl, and takes branch decisions back from the decoder/ALU flag logic.

## Interface
- PC_W, 10: program counter / ROM address width
- INSTR_W, 9: instruction width
- OFF_W, 6: signed branch offset width
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  pulse; begin execution at PC 0 from IDLE or HALT
- Stall  input  1  freeze PC and instruction register
- Branch_en  input  1  take branch for the instruction currently on Instruction
- Branch_offset  input  OFF_W  signed offset (or LUT index, see Configuration)
- Rom_addr  output  PC_W  = PC register, combinational
- Rom_data  input  INSTR_W  instruction at Rom_addr, same cycle
- Instruction  output  INSTR_W  registered instruction to decoder
- Instr_pc  output  PC_W  address of Instruction
- Instr_valid  output  1  Instruction is live and must be executed
- Done  output  1  high while in HALT

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE, PC=0, Instruction=0, Instr_pc=0, Instr_valid=0, Done=0.
- IDLE: Start -> PC<=0, RUN. Otherwise hold; Instr_valid=0.
- RUN, Stall=1: PC, Instruction, Instr_pc, Instr_valid all hold; Branch_en and halt detection ignored.
- RUN, Stall=0, Instr_valid=1, Instruction==kHALT: -> HALT, Instr_valid<=0, PC holds. Halt beats Branch_en.
- RUN, Stall=0, Instr_valid=1, Branch_en=1: PC<=target, Instr_valid<=0. The instruction being fetched is squashed, giving one bubble.
- RUN otherwise: Instruction<=Rom_data, Instr_pc<=PC, Instr_valid<=1, PC<=PC+1.
- Branch_en while Instr_valid=0 is ignored.
- target = Instr_pc + sign_extend(Branch_offset), modulo 2^PC_W.
- PC+1 wraps from 2^PC_W-1 to 0; no flag.
- HALT: Done=1, Instr_valid=0. Start -> PC<=0, Done<=0, RUN.
- Start in RUN is ignored.
- Reset asserted mid-operation forces the reset values immediately (asynchronous); the in-flight instruction is lost.

## Timing
- Start sampled at edge k: Rom_addr=0 during cycle k+1; Instruction=ROM[0] with Instr_valid=1 from edge k+2.
- Steady state: one instruction per cycle.
- Taken branch: 1 bubble cycle (Instr_valid=0), then the target instruction.
- Halt: Done rises one edge after kHALT is presented unstalled.
- Stall: 0-cycle response; outputs frozen on the same edge.

## Configuration
- BRANCH_LUT_EN defined: Branch_offset[2:0] indexes an 8-entry absolute target table kBRANCH_LUT, and target = kBRANCH_LUT[idx]. Upper offset bits are ignored.
- BRANCH_LUT_EN undefined: relative target as in Operation; no table is built.

## Structure
- Add to the shared definitions package:
  - fetch_state_t enum (IDLE, RUN, HALT)
  - kHALT = 9'b0_1111_1111
  - kBRANCH_LUT: 8 × PC_W constant array
- Sub-module branch_lut, present only under BRANCH_LUT_EN: combinational 3-bit index to PC_W target.

## Test plan
- Reset, Start pulse, ROM[0..3]=9'h101,9'h102,9'h103,9'h104: Instr_pc 0,1,2,3 on consecutive cycles from k+2, Instr_valid continuous.
- Branch_en with Instr_pc=5, offset=-3: one Instr_valid=0 cycle, then Instr_pc=2; offset=+4 from PC_W max-1 wraps to 3.
- Stall held 3 cycles at Instr_pc=7: Instruction, Instr_pc and Rom_addr constant; Branch_en during the stall has no effect; resumes at Instr_pc=8.
- ROM[4]=kHALT with Branch_en=1: Done=1 next edge, Instr_valid=0, PC frozen; Start -> Instr_pc=0 two edges later.
- Reset asserted mid-RUN between edges: all outputs at reset values immediately, state IDLE; Start is required to resume.
- BRANCH_LUT_EN with kBRANCH_LUT[3]=10'd40: Branch_offset=6'b111011 -> next valid Instr_pc=40.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//
// Shared definitions for the instruction fetch unit:
//   - widths of the program counter, instruction word and branch offset
//   - fetch_state_t  : fetch sequencer states
//   - kHALT          : opcode that stops the fetch sequencer
//   - kBRANCH_LUT    : absolute branch targets, used only when the design is
//                      built with BRANCH_LUT_EN defined
//   - sext_offset()  : sign-extends a branch offset to program-counter width
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int OFF_W   = 6;
  localparam int LUT_N   = 8;
  localparam int LUT_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [INSTR_W-1:0] kHALT = 9'b0_1111_1111;

  // Absolute branch targets, selected by Branch_offset[2:0] in the LUT build.
  localparam logic [PC_W-1:0] kBRANCH_LUT [LUT_N] = '{
    10'd0,
    10'd4,
    10'd8,
    10'd40,
    10'd100,
    10'd256,
    10'd512,
    10'd1020
  };

  // Replicates the offset's sign bit into the upper program-counter bits so the
  // subsequent add wraps modulo 2^PC_W for both forward and backward branches.
  function automatic logic [PC_W-1:0] sext_offset(input logic [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/instr_fetch_branch_lut.sv
// -----------------------------------------------------------------------------
// branch_lut
//
// Combinational lookup of an absolute branch target. Only built when
// BRANCH_LUT_EN is defined; the default build has no table at all.
//
// Ports:
//   idx     in   LUT_IDX_W  table index (low bits of the branch offset)
//   target  out  PC_W       absolute target address kBRANCH_LUT[idx]
// -----------------------------------------------------------------------------
`ifdef BRANCH_LUT_EN
module branch_lut
  import instr_fetch_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);

  always_comb begin
    target = kBRANCH_LUT[idx];
  end

endmodule
`endif

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit between the instruction ROM and the control decoder.
// It owns the program counter, presents it to the ROM (asynchronous read) and
// registers each returned instruction together with its address. Branch
// redirects squash the instruction being fetched (one bubble); a kHALT
// instruction stops the unit until Start is pulsed again.
//
// Build option:
//   BRANCH_LUT_EN  defined   : target = kBRANCH_LUT[Branch_offset[2:0]]
//                  undefined : target = Instr_pc + sign_extend(Branch_offset)
//
// Ports:
//   Clk            in   1        rising-edge clock
//   Reset          in   1        asynchronous, active-high reset
//   Start          in   1        begin execution at PC 0 from IDLE or HALT
//   Stall          in   1        freeze PC and instruction register
//   Branch_en      in   1        take branch for the instruction on Instruction
//   Branch_offset  in   OFF_W    signed offset (LUT index in the LUT build)
//   Rom_addr       out  PC_W     program counter, drives the ROM address
//   Rom_data       in   INSTR_W  ROM word at Rom_addr, same cycle
//   Instruction    out  INSTR_W  registered instruction to the decoder
//   Instr_pc       out  PC_W     address of Instruction
//   Instr_valid    out  1        Instruction is live and must be executed
//   Done           out  1        high while halted
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Branch_en,
  input  logic [OFF_W-1:0]   Branch_offset,
  output logic [PC_W-1:0]    Rom_addr,
  input  logic [INSTR_W-1:0] Rom_data,
  output logic [INSTR_W-1:0] Instruction,
  output logic [PC_W-1:0]    Instr_pc,
  output logic               Instr_valid,
  output logic               Done
);

  fetch_state_t       state_q,    state_d;
  logic [PC_W-1:0]    pc_q,       pc_d;
  logic [INSTR_W-1:0] instr_q,    instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               valid_q,    valid_d;
  logic               done_q,     done_d;

  logic [PC_W-1:0]    branch_target;

  // ---------------------------------------------------------------------------
  // Branch target
  // ---------------------------------------------------------------------------
`ifdef BRANCH_LUT_EN
  logic [PC_W-1:0] lut_target;
  // Upper offset bits carry no meaning when the offset is a table index.
  logic            lut_unused_bits;

  assign lut_unused_bits = ^Branch_offset[OFF_W-1:LUT_IDX_W];

  branch_lut u_branch_lut (
    .idx    (Branch_offset[LUT_IDX_W-1:0]),
    .target (lut_target)
  );

  always_comb begin
    branch_target = lut_target;
  end
`else
  // Relative to the address of the branching instruction, not the fetch PC,
  // which has already moved one ahead.
  always_comb begin
    branch_target = instr_pc_q + sext_offset(Branch_offset);
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    done_d     = done_q;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (Start) begin
          pc_d    = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Stall freezes everything, including halt and branch decisions.
        // Start is deliberately not looked at while running.
        if (!Stall) begin
          if (valid_q && (instr_q == kHALT)) begin
            // Halt has priority over a simultaneous branch; PC stays put.
            state_d = HALT;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (valid_q && Branch_en) begin
            // Redirect and drop the word on Rom_data: one bubble cycle.
            pc_d    = branch_target;
            valid_d = 1'b0;
          end else begin
            instr_d    = Rom_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 1'b1;  // wraps silently at 2^PC_W
          end
        end
      end

      HALT: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        if (Start) begin
          pc_d    = '0;
          done_d  = 1'b0;
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples the values
  // computed before this edge, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Rom_addr    = pc_q;
  assign Instruction = instr_q;
  assign Instr_pc    = instr_pc_q;
  assign Instr_valid = valid_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. The ROM is a bench-side array read
// combinationally at Rom_addr. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic               Clk;
  logic               Reset;
  logic               Start;
  logic               Stall;
  logic               Branch_en;
  logic [OFF_W-1:0]   Branch_offset;
  logic [PC_W-1:0]    Rom_addr;
  logic [INSTR_W-1:0] Rom_data;
  logic [INSTR_W-1:0] Instruction;
  logic [PC_W-1:0]    Instr_pc;
  logic               Instr_valid;
  logic               Done;

  logic [INSTR_W-1:0] rom [1 << PC_W];

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .Stall         (Stall),
    .Branch_en     (Branch_en),
    .Branch_offset (Branch_offset),
    .Rom_addr      (Rom_addr),
    .Rom_data      (Rom_data),
    .Instruction   (Instruction),
    .Instr_pc      (Instr_pc),
    .Instr_valid   (Instr_valid),
    .Done          (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign Rom_data = rom[Rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // A live instruction at address pc with the given word.
  task automatic check_live(input string tag, input int pc, input logic [INSTR_W-1:0] ins);
    check({tag, ".valid"}, 32'(Instr_valid), 32'd1);
    check({tag, ".pc"},    32'(Instr_pc),    32'(pc));
    check({tag, ".instr"}, 32'(Instruction), 32'(ins));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".rom_addr"}, 32'(Rom_addr),    32'd0);
    check({tag, ".instr"},    32'(Instruction), 32'd0);
    check({tag, ".pc"},       32'(Instr_pc),    32'd0);
    check({tag, ".valid"},    32'(Instr_valid), 32'd0);
    check({tag, ".done"},     32'(Done),        32'd0);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << PC_W); i++)
      rom[i] = (i < 16) ? 9'(9'h101 + i) : 9'h0AA;
    rom[40]   = 9'h0C8;
    rom[1023] = 9'h1F0;

    Reset = 1'b1; Start = 1'b0; Stall = 1'b0;
    Branch_en = 1'b0; Branch_offset = '0;
    #1;
    check_reset_values("por");
    @(negedge Clk);
    Reset = 1'b0;

    // IDLE holds without Start.
    step(); step();
    check("idle.valid", 32'(Instr_valid), 32'd0);
    check("idle.addr",  32'(Rom_addr),    32'd0);

    // Start: one cycle presenting address 0, then back-to-back fetches.
    pulse_start();
    check("start.addr",  32'(Rom_addr),    32'd0);
    check("start.valid", 32'(Instr_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_live($sformatf("seq%0d", i), i, 9'(9'h101 + i));
    end
    check("seq5.addr", 32'(Rom_addr), 32'd6);

`ifdef BRANCH_LUT_EN
    // Index 3 (offset 6'b111011, upper bits ignored) selects address 40.
    Branch_en = 1'b1; Branch_offset = 6'b111011;
    step();
    Branch_en = 1'b0;
    check("lut.bubble", 32'(Instr_valid), 32'd0);
    check("lut.addr",   32'(Rom_addr),    32'd40);
    step();
    check_live("lut.tgt", 40, 9'h0C8);
`else
    // Branch at pc 5, offset -3 -> 2. Branch_en stays high through the bubble,
    // where it must be ignored; then pc 2 branches -3 again, wrapping to 1023.
    Branch_en = 1'b1; Branch_offset = 6'b111101;
    step();
    check("br1.bubble", 32'(Instr_valid), 32'd0);
    check("br1.addr",   32'(Rom_addr),    32'd2);
    step();
    check_live("br1.tgt", 2, 9'h103);
    step();
    Branch_en = 1'b0;
    check("br2.bubble", 32'(Instr_valid), 32'd0);
    check("br2.addr",   32'(Rom_addr),    32'd1023);
    step();
    check_live("br2.tgt", 1023, 9'h1F0);
    check("pc_wrap.addr", 32'(Rom_addr), 32'd0);

    // +4 from 1023 wraps to 3.
    Branch_en = 1'b1; Branch_offset = 6'b000100;
    step();
    Branch_en = 1'b0;
    check("br3.bubble", 32'(Instr_valid), 32'd0);
    check("br3.addr",   32'(Rom_addr),    32'd3);
    for (int i = 3; i <= 7; i++) begin
      step();
      check_live($sformatf("seqb%0d", i), i, 9'(9'h101 + i));
    end

    // Stall at pc 7 for three cycles with a branch request pending.
    Stall = 1'b1; Branch_en = 1'b1; Branch_offset = 6'b111000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_live($sformatf("stall%0d", i), 7, 9'h108);
      check($sformatf("stall%0d.addr", i), 32'(Rom_addr), 32'd8);
    end
    Stall = 1'b0; Branch_en = 1'b0;
    step();
    check_live("resume", 8, 9'h109);

    // Halt: branch -4 to address 4, which now holds kHALT; a branch request
    // alongside the halt must lose.
    rom[4] = kHALT;
    Branch_en = 1'b1; Branch_offset = 6'b111100;
    step();
    check("br4.addr", 32'(Rom_addr), 32'd4);
    Branch_offset = 6'b000010;
    step();
    check_live("halt.instr", 4, kHALT);
    step();
    Branch_en = 1'b0;
    check("halt.done",  32'(Done),        32'd1);
    check("halt.valid", 32'(Instr_valid), 32'd0);
    check("halt.addr",  32'(Rom_addr),    32'd5);
    step();
    check("halt2.done", 32'(Done),     32'd1);
    check("halt2.addr", 32'(Rom_addr), 32'd5);
    rom[4] = 9'h105;

    pulse_start();
    check("restart.done",  32'(Done),        32'd0);
    check("restart.addr",  32'(Rom_addr),    32'd0);
    check("restart.valid", 32'(Instr_valid), 32'd0);
    // Start while running is ignored.
    Start = 1'b1;
    step();
    check_live("restart.pc0", 0, 9'h101);
    step();
    Start = 1'b0;
    check_live("run_start", 1, 9'h102);
    check("run_start.addr", 32'(Rom_addr), 32'd2);
`endif

    // Asynchronous reset between edges while running.
    #3;
    Reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge Clk);
    Reset = 1'b0;
    step(); step();
    check("postrst.valid", 32'(Instr_valid), 32'd0);
    check("postrst.addr",  32'(Rom_addr),    32'd0);
    pulse_start();
    step();
    check_live("postrst.run", 0, 9'h101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
